demux_sel_driver: RTL and testbench

- Upstream stage of the 1x8 demux tree: accepts one 8-bit byte per valid/ready handshake and walks the byte out bit by bit.
- For each bit it drives the demux select `sel[2:0]` and serial data bit `i`, so bit n of the byte appears on demux output yn.
- A strobe marks the cycles where `sel`/`i` are meaningful. A one-cycle done pulse closes each byte.
- Sits between the byte-wide producer and the combinational demux1x8 instance.

---
 rtl/demux_sel_driver_pkg.sv | 21 ++
 rtl/demux_sel_driver_if.sv | 24 ++
 rtl/demux_hold_counter.sv | 40 ++++
 rtl/demux_sel_driver.sv | 119 +++++++++++
 tb/tb_demux_sel_driver.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_sel_driver_pkg.sv
// Shared constants and state encoding for the demux select driver and the demux1x8 wrapper.
package demux_sel_driver_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned DATA_W  = NUM_OUT;
  localparam int unsigned HOLD_W  = 4;
  localparam int unsigned BIT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // First select index of a byte, depending on bit order.
  function automatic logic [SEL_W-1:0] start_sel(input logic msb_first);
    return msb_first ? SEL_W'(NUM_OUT - 1) : '0;
  endfunction

endpackage

// File: rtl/demux_sel_driver_if.sv
// Byte handshake plus select/bit outputs between producer, driver and demux.
interface demux_sel_driver_if;
  import demux_sel_driver_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic [SEL_W-1:0]  sel;
  logic              i;
  logic              stb;
  logic              done;
  logic              busy;

  modport slave (
    input  data, valid,
    output ready, sel, i, stb, done, busy
  );

  modport master (
    output data, valid,
    input  ready, sel, i, stb, done, busy
  );

endinterface

// File: rtl/demux_hold_counter.sv
// Per-bit hold timer and bit-step counter; flags the cycle a bit's hold expires.
module demux_hold_counter
  import demux_sel_driver_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_run,
  output logic o_step_c,
  output logic o_last_bit_c
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NUM_OUT - 1);

  logic [HOLD_W-1:0] r_hold;
  logic [BIT_W-1:0]  r_bit;

  assign o_step_c     = i_run && (r_hold == HOLD_LAST);
  assign o_last_bit_c = (r_bit == BIT_LAST);

  // Counts bits rather than select values so the select wrap cannot add a ninth bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_bit  <= '0;
    end else if (i_start) begin
      r_hold <= '0;
      r_bit  <= '0;
    end else if (o_step_c) begin
      r_hold <= '0;
      r_bit  <= r_bit + BIT_W'(1);
    end else if (i_run) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/demux_sel_driver.sv
// Accepts a byte per handshake and walks it out bit by bit as demux select plus serial bit.
module demux_sel_driver
  import demux_sel_driver_pkg::*;
#(
  parameter int unsigned HOLD_CYC  = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  demux_sel_driver_if.slave bus
);

  localparam logic [SEL_W-1:0] START_SEL = start_sel(MSB_FIRST);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_buf;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [SEL_W-1:0]  w_sel_step;
  logic              r_i;
  logic              w_i_nxt;
  logic              r_stb;
  logic              w_stb_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_accept;
  logic              w_step;
  logic              w_last_bit;

  assign w_accept   = (r_state == ST_IDLE) && bus.valid;
  assign w_sel_step = MSB_FIRST ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));

  demux_hold_counter #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_accept),
    .i_run        (r_state == ST_SHIFT),
    .o_step_c     (w_step),
    .o_last_bit_c (w_last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_step && w_last_bit) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; done defaults low so it only ever pulses.
  always_comb begin
    w_sel_nxt  = r_sel;
    w_i_nxt    = r_i;
    w_stb_nxt  = r_stb;
    w_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_sel_nxt = START_SEL;
          w_i_nxt   = bus.data[START_SEL];
          w_stb_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_step) begin
          if (w_last_bit) begin
            w_sel_nxt  = '0;
            w_i_nxt    = 1'b0;
            w_stb_nxt  = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            w_sel_nxt = w_sel_step;
            w_i_nxt   = r_buf[w_sel_step];
          end
        end
      end
      ST_DONE: ;
      default: begin
        w_sel_nxt = '0;
        w_i_nxt   = 1'b0;
        w_stb_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= '0;
      r_i    <= 1'b0;
      r_stb  <= 1'b0;
      r_done <= 1'b0;
      r_buf  <= '0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_i    <= w_i_nxt;
      r_stb  <= w_stb_nxt;
      r_done <= w_done_nxt;
      if (w_accept) r_buf <= bus.data;
    end
  end

  assign bus.sel   = r_sel;
  assign bus.i     = r_i;
  assign bus.stb   = r_stb;
  assign bus.done  = r_done;
  assign bus.ready = (r_state == ST_IDLE);
  assign bus.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_demux_sel_driver.sv
// Bench for demux_sel_driver: three parameterisations checked against a cycle-position model.
module tb_demux_sel_driver;

  localparam logic [7:0] EXP_IDLE = 8'b000_0_0_0_1_0;
  localparam logic [7:0] EXP_DONE = 8'b000_0_0_1_0_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  demux_sel_driver_if u_if0 ();
  demux_sel_driver_if u_if1 ();
  demux_sel_driver_if u_if2 ();

  assign u_if0.data = data;  assign u_if0.valid = valid;
  assign u_if1.data = data;  assign u_if1.valid = valid;
  assign u_if2.data = data;  assign u_if2.valid = valid;

  demux_sel_driver #(.HOLD_CYC(1), .MSB_FIRST(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0.slave));
  demux_sel_driver #(.HOLD_CYC(1), .MSB_FIRST(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave));
  demux_sel_driver #(.HOLD_CYC(3), .MSB_FIRST(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2.slave));

  // Observed outputs packed as {sel, i, stb, done, ready, busy}.
  logic [7:0] o_vec [3];
  assign o_vec[0] = {u_if0.sel, u_if0.i, u_if0.stb, u_if0.done, u_if0.ready, u_if0.busy};
  assign o_vec[1] = {u_if1.sel, u_if1.i, u_if1.stb, u_if1.done, u_if1.ready, u_if1.busy};
  assign o_vec[2] = {u_if2.sel, u_if2.i, u_if2.stb, u_if2.done, u_if2.ready, u_if2.busy};

  function automatic int hold_of(int d);
    return (d == 2) ? 3 : 1;
  endfunction

  function automatic bit msb_of(int d);
    return (d == 1);
  endfunction

  // Model: m_c = cycles since the accepting edge (0 = idle); outputs follow from position alone.
  int         m_c     [3] = '{0, 0, 0};
  logic [7:0] m_data  [3];
  int         acc_cyc [3] = '{0, 0, 0};
  int         n_acc   [3] = '{0, 0, 0};
  int         done_cyc[3] = '{0, 0, 0};
  int         done_cnt[3] = '{0, 0, 0};
  int         i_cnt   [3] = '{0, 0, 0};
  logic [7:0] ymask   [3];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst) m_c[d] = 0;
      else if (m_c[d] == 0) begin
        if (valid) begin
          m_c[d]     = 1;
          m_data[d]  = data;
          acc_cyc[d] = cyc;
          n_acc[d]   = n_acc[d] + 1;
        end
      end else if (m_c[d] == 8 * hold_of(d) + 1) m_c[d] = 0;
      else m_c[d] = m_c[d] + 1;
    end
  end

  function automatic logic [7:0] model_exp(int d);
    int         c;
    int         n;
    logic [2:0] s;
    c = m_c[d];
    if (c == 0) return EXP_IDLE;
    if (c <= 8 * hold_of(d)) begin
      n = (c - 1) / hold_of(d);
      s = msb_of(d) ? 3'(7 - n) : 3'(n);
      return {s, m_data[d][s], 1'b1, 1'b0, 1'b0, 1'b1};
    end
    return EXP_DONE;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got {sel,i,stb,done,ready,busy}=%b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance one cycle, compare every DUT to the model, and collect observations.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("model d%0d", d), o_vec[d], model_exp(d));
      if (o_vec[d][2]) begin
        done_cyc[d] = cyc;
        done_cnt[d] = done_cnt[d] + 1;
      end
      if (o_vec[d][4]) i_cnt[d] = i_cnt[d] + 1;
      if (o_vec[d][3] && o_vec[d][4]) ymask[d][o_vec[d][7:5]] = 1'b1;
    end
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 3; d++) begin
      i_cnt[d] = 0;
      ymask[d] = 8'h00;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 80; k++) begin
      if (!(o_vec[0][0] || o_vec[1][0] || o_vec[2][0])) break;
      step();
    end
    check_int("drain busy", int'(o_vec[0][0] || o_vec[1][0] || o_vec[2][0]), 0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [11];
  int   first_acc;
  int   base;
  int   dn;

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, EXP_IDLE};
    tbl[1]  = '{1'b0, 8'h00, 8'b000_1_1_0_0_1};
    tbl[2]  = '{1'b0, 8'h00, 8'b001_0_1_0_0_1};
    tbl[3]  = '{1'b0, 8'h00, 8'b010_1_1_0_0_1};
    tbl[4]  = '{1'b0, 8'h00, 8'b011_0_1_0_0_1};
    tbl[5]  = '{1'b0, 8'h00, 8'b100_0_1_0_0_1};
    tbl[6]  = '{1'b0, 8'h00, 8'b101_1_1_0_0_1};
    tbl[7]  = '{1'b0, 8'h00, 8'b110_0_1_0_0_1};
    tbl[8]  = '{1'b0, 8'h00, 8'b111_1_1_0_0_1};
    tbl[9]  = '{1'b0, 8'h00, EXP_DONE};
    tbl[10] = '{1'b0, 8'h00, EXP_IDLE};

    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    step();
    step();
    check("reset d0", o_vec[0], EXP_IDLE);
    check("reset d2", o_vec[2], EXP_IDLE);
    rst = 1'b0;

    // A5, LSB-first table on d0; d1 (MSB-first) and d2 (hold 3) see the same byte.
    clear_obs();
    for (int t = 0; t < 11; t++) begin
      check($sformatf("tbl A5 t%0d", t), o_vec[0], tbl[t].exp);
      valid = tbl[t].v;
      data  = tbl[t].d;
      step();
    end
    check_int("A5 d0 done latency", done_cyc[0] - acc_cyc[0] + 1, 9);
    check_int("A5 d1 done latency", done_cyc[1] - acc_cyc[1] + 1, 9);
    check_int("A5 d0 y pulses", int'(ymask[0]), 8'hA5);
    check_int("A5 d1 y pulses", int'(ymask[1]), 8'hA5);
    drain();

    // Hold 3, byte 01: bit high only for the sel=0 hold.
    clear_obs();
    valid = 1'b1;
    data  = 8'h01;
    step();
    valid = 1'b0;
    drain();
    check_int("01 d2 i-high cycles", i_cnt[2], 3);
    check_int("01 d2 done latency", done_cyc[2] - acc_cyc[2] + 1, 25);
    check_int("01 d0 i-high cycles", i_cnt[0], 1);

    // Back-to-back FF then 00 with valid held; data scrambled while d0 is busy.
    clear_obs();
    valid     = 1'b1;
    data      = 8'hFF;
    base      = n_acc[0];
    first_acc = -1;
    for (int k = 0; k < 40 && (n_acc[0] - base) < 2; k++) begin
      step();
      if ((n_acc[0] - base) == 1) begin
        if (first_acc < 0) first_acc = acc_cyc[0];
        data = o_vec[0][1] ? 8'h00 : 8'($urandom);
      end
    end
    valid = 1'b0;
    check_int("b2b accepts", n_acc[0] - base, 2);
    check_int("b2b gap", acc_cyc[0] - first_acc, 10);
    drain();
    check_int("b2b d0 y pulses", int'(ymask[0]), 8'hFF);

    // Abort C3 at its 4th bit, then stream 3C.
    valid = 1'b1;
    data  = 8'hC3;
    step();
    valid = 1'b0;
    for (int k = 0; k < 10 && !(o_vec[0][3] && o_vec[0][7:5] == 3'd3); k++) step();
    check("abort at bit 3", o_vec[0], 8'b011_0_1_0_0_1);
    rst = 1'b1;
    dn  = done_cnt[0];
    step();
    check("abort reset d0", o_vec[0], EXP_IDLE);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check_int("abort no done", done_cnt[0] - dn, 0);
    clear_obs();
    valid = 1'b1;
    data  = 8'h3C;
    step();
    valid = 1'b0;
    drain();
    check_int("3C d0 y pulses", int'(ymask[0]), 8'h3C);
    check_int("3C d1 y pulses", int'(ymask[1]), 8'h3C);

    // Valid low: nothing moves.
    dn = done_cnt[0];
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle hold d0", o_vec[0], EXP_IDLE);
    end
    check_int("idle no done", done_cnt[0] - dn, 0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      valid = ($urandom_range(2) == 0);
      data  = 8'($urandom);
      rst   = ($urandom_range(249) == 0);
      step();
    end
    rst   = 1'b0;
    valid = 1'b0;
    step();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
